pedestrian_xing_ctrl: RTL and testbench
=======================================

PEDESTRIAN_XING_CTRL -- requirements
Module: pedestrian_xing_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 12_000_000, giving clk cycles per time tick (legal range 1..2^32-1).
REQ-002 The block SHALL have parameter GREEN_T, default 5, giving the minimum car-green time in ticks (legal range >=1).
REQ-003 The block SHALL have parameter YELLOW_T, default 2, giving the car-yellow time in ticks (legal range >=1).
REQ-004 The block SHALL have parameter ALLRED_T, default 1, giving the all-red clearance time in ticks (legal range >=1).
REQ-005 The block SHALL have parameter WALK_T, default 3, giving the pedestrian-green time in ticks (legal range >=1).
REQ-006 The block SHALL have parameter CNT_W, default 8, giving the phase-counter width; every *_T value SHALL fit in CNT_W bits.
REQ-007 The block SHALL have parameter DEB_CYC, default 4, giving the debounce length in clk cycles (legal range >=1).
REQ-008 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 Port rst, input, 1 bit: synchronous, active-low reset.
REQ-010 Port buton, input, 1 bit: asynchronous pedestrian push-button, active-low.
REQ-011 Port night, input, 1 bit: asynchronous night-mode request, active-high.
REQ-012 Ports car_red, car_yellow, car_green, ped_red, ped_green, output, 1 bit each: lamp drives, active-high.
REQ-013 Port led, output, 8 bits: active-low board LEDs, led = ~{ped_red, ped_green, 3'b000, car_red, car_green, car_yellow}.
REQ-014 Port remaining, output, CNT_W bits: ticks left in the current timed phase.
REQ-015 Port req_pending, output, 1 bit: a latched pedestrian request is waiting.
REQ-016 Port tick, output, 1 bit: a one-clk pulse marking each time tick.

Function
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 and SHALL assert tick for exactly the cycle in which it equals TICK_DIV-1, then wrap to 0; with TICK_DIV=1, tick SHALL be constantly 1.
REQ-018 buton and night SHALL each pass a 2-FF synchroniser before use.
REQ-019 The synchronised buton SHALL set req_pending only after it has been low for DEB_CYC consecutive clk cycles; a release shorter than DEB_CYC cycles SHALL restart the debounce count.
REQ-020 req_pending SHALL be set in GREEN, YELLOW and ALL_RED, and SHALL be ignored in WALK and NIGHT.
REQ-021 req_pending SHALL clear on the edge that enters WALK or NIGHT; clear SHALL win over a simultaneous set.
REQ-022 The FSM SHALL have states GREEN, YELLOW, ALL_RED, WALK and NIGHT; phase_cnt SHALL be 0 on entry to every state and SHALL advance only on tick.
REQ-023 GREEN: phase_cnt SHALL increment on tick and saturate at GREEN_T-1; on a tick with phase_cnt==GREEN_T-1, the FSM SHALL go to NIGHT if night_sync=1, else to YELLOW if req_pending=1, else stay in GREEN.
REQ-024 In YELLOW, ALL_RED and WALK, on a tick with phase_cnt==DUR-1 (DUR being the respective *_T), the FSM SHALL advance YELLOW->ALL_RED, ALL_RED->WALK and WALK->GREEN; each of these phases therefore lasts exactly DUR ticks.
REQ-025 A night request during YELLOW, ALL_RED or WALK SHALL NOT abort the sequence; it SHALL take effect at the GREEN exit point.
REQ-026 NIGHT: car_yellow SHALL toggle on every tick, all other lamps SHALL be 0, and on a tick with night_sync=0 the FSM SHALL go to GREEN.
REQ-027 Lamp decode SHALL be Moore, from the state register, with no added latency:
- GREEN: car_green=1, ped_red=1.
- YELLOW: car_yellow=1, ped_red=1.
- ALL_RED: car_red=1, ped_red=1.
- WALK: car_red=1, ped_green=1.
REQ-028 remaining SHALL equal DUR-1-phase_cnt in every timed state (GREEN uses DUR=GREEN_T, which gives 0 once saturated), and SHALL be 0 in NIGHT.
REQ-029 Undefined state encodings SHALL recover to GREEN with phase_cnt=0 on the next edge.

Reset
REQ-030 While rst=0 at a clk edge, the block SHALL load:
- state=GREEN, phase_cnt=0, prescaler=0, debounce count=0, synchronisers=idle (buton 1, night 0).
- req_pending=0, tick=0.
- Outputs car_green=1, ped_red=1, all other lamps 0, led=8'b0111_1101, remaining=GREEN_T-1.
REQ-031 Reset asserted mid-phase (including WALK or NIGHT) SHALL take effect on the next edge with no sequence completion.

Verification (TICK_DIV=4, GREEN_T=5, YELLOW_T=2, ALLRED_T=1, WALK_T=3, DEB_CYC=2)
REQ-032 Reset then idle for 100 cycles -> tick pulses every 4th cycle; state stays GREEN; remaining counts 4,3,2,1,0 and holds at 0; led=8'b0111_1101.
REQ-033 buton low for 3 cycles at cycle 2 -> req_pending=1 about 5 cycles later; YELLOW on the 5th tick; then exactly 2 ticks YELLOW (led=8'b0111_1110), 1 tick ALL_RED, 3 ticks WALK (led=8'b1011_1011), then GREEN.
REQ-034 buton pulse of 1 cycle, or pressed only during WALK -> req_pending stays 0 and no new cycle starts.
REQ-035 night=1 asserted during YELLOW -> sequence completes through WALK; NIGHT is entered after 5 ticks of GREEN; car_yellow toggles every tick; night=0 -> GREEN on the next tick with remaining=4.
REQ-036 rst=0 for 1 cycle during WALK -> next edge shows GREEN reset values and req_pending=0.

Source files
------------

// File: rtl/pedestrian_xing_ctrl.sv
// rtl/pedestrian_xing_ctrl.sv - pedestrian crossing lamp controller with debounced request and night blink
module pedestrian_xing_ctrl #(
  parameter int unsigned TICK_DIV = 12_000_000,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 3,
  parameter int CNT_W    = 8,
  parameter int DEB_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             buton,
  input  logic             night,
  output logic             car_red,
  output logic             car_yellow,
  output logic             car_green,
  output logic             ped_red,
  output logic             ped_green,
  output logic [7:0]       led,
  output logic [CNT_W-1:0] remaining,
  output logic             req_pending,
  output logic             tick
);

  localparam logic [2:0] S_GREEN  = 3'd0;
  localparam logic [2:0] S_YELLOW = 3'd1;
  localparam logic [2:0] S_ALLRED = 3'd2;
  localparam logic [2:0] S_WALK   = 3'd3;
  localparam logic [2:0] S_NIGHT  = 3'd4;

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WALK_T - 1);

  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [31:0] PRESC_LAST = 32'(TICK_DIV - 1);

  logic [31:0]      presc;
  logic             buton_s1, buton_s2, night_s1, night_s2;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_set;
  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] phase_cnt, cnt_nxt;
  logic             blink;
  logic             enter_clear;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (!rst) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buton_s1 <= 1'b1;
      buton_s2 <= 1'b1;
      night_s1 <= 1'b0;
      night_s2 <= 1'b0;
    end else begin
      buton_s1 <= buton;
      buton_s2 <= buton_s1;
      night_s1 <= night;
      night_s2 <= night_s1;
    end
  end

  // deb_cnt holds the number of earlier consecutive low cycles, saturating at DEB_CYC-1
  always_ff @(posedge clk) begin
    if (!rst || buton_s2) deb_cnt <= '0;
    else if (deb_cnt != DEB_LAST) deb_cnt <= deb_cnt + DEB_W'(1);
  end

  assign deb_set = !buton_s2 && (deb_cnt == DEB_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = phase_cnt;
    case (state)
      S_GREEN: if (tick) begin
        if (phase_cnt == G_LAST) begin
          if (night_s2) begin
            state_nxt = S_NIGHT;
            cnt_nxt   = '0;
          end else if (req_pending) begin
            state_nxt = S_YELLOW;
            cnt_nxt   = '0;
          end
        end else cnt_nxt = phase_cnt + CNT_W'(1);
      end
      S_YELLOW: if (tick) begin
        if (phase_cnt == Y_LAST) begin
          state_nxt = S_ALLRED;
          cnt_nxt   = '0;
        end else cnt_nxt = phase_cnt + CNT_W'(1);
      end
      S_ALLRED: if (tick) begin
        if (phase_cnt == A_LAST) begin
          state_nxt = S_WALK;
          cnt_nxt   = '0;
        end else cnt_nxt = phase_cnt + CNT_W'(1);
      end
      S_WALK: if (tick) begin
        if (phase_cnt == W_LAST) begin
          state_nxt = S_GREEN;
          cnt_nxt   = '0;
        end else cnt_nxt = phase_cnt + CNT_W'(1);
      end
      S_NIGHT: if (tick && !night_s2) begin
        state_nxt = S_GREEN;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_GREEN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign enter_clear = (state_nxt == S_WALK  && state != S_WALK) ||
                       (state_nxt == S_NIGHT && state != S_NIGHT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_GREEN;
      phase_cnt   <= '0;
      req_pending <= 1'b0;
      blink       <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= cnt_nxt;
      if (enter_clear) req_pending <= 1'b0;
      else if (deb_set && (state == S_GREEN || state == S_YELLOW || state == S_ALLRED))
        req_pending <= 1'b1;
      if (state != S_NIGHT) blink <= 1'b0;
      else if (tick) blink <= ~blink;
    end
  end

  always_comb begin
    car_red    = 1'b0;
    car_yellow = 1'b0;
    car_green  = 1'b0;
    ped_red    = 1'b0;
    ped_green  = 1'b0;
    remaining  = '0;
    case (state)
      S_GREEN:  begin car_green  = 1'b1; ped_red   = 1'b1; remaining = G_LAST - phase_cnt; end
      S_YELLOW: begin car_yellow = 1'b1; ped_red   = 1'b1; remaining = Y_LAST - phase_cnt; end
      S_ALLRED: begin car_red    = 1'b1; ped_red   = 1'b1; remaining = A_LAST - phase_cnt; end
      S_WALK:   begin car_red    = 1'b1; ped_green = 1'b1; remaining = W_LAST - phase_cnt; end
      S_NIGHT:  car_yellow = blink;
      default:  ;
    endcase
  end

  assign led = ~{ped_red, ped_green, 3'b000, car_red, car_green, car_yellow};

endmodule

// File: tb/tb_pedestrian_xing_ctrl.sv
// tb/tb_pedestrian_xing_ctrl.sv - directed self-checking bench for pedestrian_xing_ctrl
module tb_pedestrian_xing_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       buton = 1'b1;
  logic       night = 1'b0;
  logic       car_red, car_yellow, car_green, ped_red, ped_green;
  logic [7:0] led;
  logic [7:0] remaining;
  logic       req_pending, tick;
  logic [4:0] lamps;

  int tests_run = 0;
  int tests_failed = 0;

  assign lamps = {car_red, car_yellow, car_green, ped_red, ped_green};

  pedestrian_xing_ctrl #(
    .TICK_DIV(4), .GREEN_T(5), .YELLOW_T(2), .ALLRED_T(1),
    .WALK_T(3), .CNT_W(8), .DEB_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .buton(buton), .night(night),
    .car_red(car_red), .car_yellow(car_yellow), .car_green(car_green),
    .ped_red(ped_red), .ped_green(ped_green), .led(led),
    .remaining(remaining), .req_pending(req_pending), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    buton = 1'b1;
    night = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Press buton for 3 cycles starting at cycle 2, then run to the end of GREEN.
  task automatic run_to_yellow(output int green_ticks, output int req_cyc);
    green_ticks = 0;
    req_cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (req_pending && req_cyc < 0) req_cyc = k;
      if (!car_green) break;
      if (tick) green_ticks++;
      buton = (k >= 2 && k < 5) ? 1'b0 : 1'b1;
    end
    buton = 1'b1;
  endtask

  // Count ticks until the lamp pattern changes; ok=0 if it never does.
  task automatic measure_phase(output int ticks, output logic ok);
    logic [4:0] start;
    start = lamps;
    ticks = 0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (tick) ticks++;
      @(negedge clk);
      if (lamps !== start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic tick_step(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (tick) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (lamps !== 5'b00110) begin
      tests_failed++;
      $display("FAIL reset_lamps got %b want 00110", lamps);
    end
    tests_run++;
    if (led !== 8'b0111_1101) begin
      tests_failed++;
      $display("FAIL reset_led got %b want 01111101", led);
    end
    tests_run++;
    if (remaining !== 8'd4 || req_pending !== 1'b0 || tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_misc got rem=%0d req=%b tick=%b want 4 0 0", remaining, req_pending, tick);
    end
  endtask

  task automatic test_idle();
    logic exp_tick;
    int exp_rem;
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      exp_tick = (k % 4 == 3);
      exp_rem = (k / 4 >= 4) ? 0 : 4 - k / 4;
      tests_run++;
      if (tick !== exp_tick) begin
        tests_failed++;
        $display("FAIL idle_tick cyc %0d got %b want %b", k, tick, exp_tick);
      end
      tests_run++;
      if (remaining !== 8'(exp_rem)) begin
        tests_failed++;
        $display("FAIL idle_remaining cyc %0d got %0d want %0d", k, remaining, exp_rem);
      end
    end
    tests_run++;
    if (led !== 8'b0111_1101 || req_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_end got led=%b req=%b want 01111101 0", led, req_pending);
    end
  endtask

  task automatic test_request();
    int gt, rq, t;
    logic ok, saw;
    do_reset();
    run_to_yellow(gt, rq);
    tests_run++;
    if (rq !== 6) begin
      tests_failed++;
      $display("FAIL req_latency got cyc %0d want 6", rq);
    end
    tests_run++;
    if (gt !== 5 || car_yellow !== 1'b1) begin
      tests_failed++;
      $display("FAIL green_ticks got %0d yellow=%b want 5 1", gt, car_yellow);
    end
    tests_run++;
    if (led !== 8'b0111_1110 || remaining !== 8'd1) begin
      tests_failed++;
      $display("FAIL yellow_out got led=%b rem=%0d want 01111110 1", led, remaining);
    end
    measure_phase(t, ok);
    tests_run++;
    if (!ok || t !== 2 || lamps !== 5'b10010) begin
      tests_failed++;
      $display("FAIL yellow_ticks got %0d lamps=%b want 2 10010", t, lamps);
    end
    measure_phase(t, ok);
    tests_run++;
    if (!ok || t !== 1 || lamps !== 5'b10001) begin
      tests_failed++;
      $display("FAIL allred_ticks got %0d lamps=%b want 1 10001", t, lamps);
    end
    tests_run++;
    if (led !== 8'b1011_1011 || req_pending !== 1'b0 || remaining !== 8'd2) begin
      tests_failed++;
      $display("FAIL walk_entry got led=%b req=%b rem=%0d want 10111011 0 2", led, req_pending, remaining);
    end
    // Press during WALK only: must be ignored.
    buton = 1'b0;
    repeat (3) @(negedge clk);
    buton = 1'b1;
    measure_phase(t, ok);
    t = t + 0;
    tests_run++;
    if (!ok || lamps !== 5'b00110 || remaining !== 8'd4) begin
      tests_failed++;
      $display("FAIL walk_exit got lamps=%b rem=%0d want 00110 4", lamps, remaining);
    end
    saw = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_pending !== 1'b0 || car_green !== 1'b1) saw = 1'b1;
    end
    tests_run++;
    if (saw) begin
      tests_failed++;
      $display("FAIL walk_press_ignored got req/cycle activity=1 want 0");
    end
  endtask

  task automatic test_short_pulse();
    logic saw;
    do_reset();
    repeat (2) @(negedge clk);
    buton = 1'b0;
    @(negedge clk);
    buton = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_pending !== 1'b0 || car_green !== 1'b1) saw = 1'b1;
    end
    tests_run++;
    if (saw) begin
      tests_failed++;
      $display("FAIL short_pulse got req/cycle activity=1 want 0");
    end
  endtask

  task automatic test_night();
    int gt, rq, t;
    logic ok;
    do_reset();
    run_to_yellow(gt, rq);
    night = 1'b1;
    measure_phase(t, ok);
    measure_phase(t, ok);
    tests_run++;
    if (!ok || lamps !== 5'b10001) begin
      tests_failed++;
      $display("FAIL night_no_abort got lamps=%b want 10001", lamps);
    end
    measure_phase(t, ok);
    measure_phase(t, ok);
    tests_run++;
    if (!ok || t !== 5 || lamps !== 5'b00000) begin
      tests_failed++;
      $display("FAIL night_entry got green_ticks=%0d lamps=%b want 5 00000", t, lamps);
    end
    tests_run++;
    if (remaining !== 8'd0 || led !== 8'hFF || req_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL night_out got rem=%0d led=%b req=%b want 0 11111111 0", remaining, led, req_pending);
    end
    tick_step(ok);
    tests_run++;
    if (!ok || lamps !== 5'b01000) begin
      tests_failed++;
      $display("FAIL night_blink_on got lamps=%b want 01000", lamps);
    end
    tick_step(ok);
    tests_run++;
    if (!ok || lamps !== 5'b00000) begin
      tests_failed++;
      $display("FAIL night_blink_off got lamps=%b want 00000", lamps);
    end
    night = 1'b0;
    tick_step(ok);
    tests_run++;
    if (!ok || lamps !== 5'b00110 || remaining !== 8'd4) begin
      tests_failed++;
      $display("FAIL night_exit got lamps=%b rem=%0d want 00110 4", lamps, remaining);
    end
  endtask

  task automatic test_reset_in_walk();
    int gt, rq, t;
    logic ok;
    do_reset();
    run_to_yellow(gt, rq);
    measure_phase(t, ok);
    measure_phase(t, ok);
    tick_step(ok);
    tests_run++;
    if (ped_green !== 1'b1 || remaining !== 8'd1) begin
      tests_failed++;
      $display("FAIL mid_walk got ped_green=%b rem=%0d want 1 1", ped_green, remaining);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (lamps !== 5'b00110 || led !== 8'b0111_1101 || remaining !== 8'd4 || req_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL walk_reset got lamps=%b led=%b rem=%0d req=%b want 00110 01111101 4 0",
               lamps, led, remaining, req_pending);
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_request();
    test_short_pulse();
    test_night();
    test_reset_in_walk();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
